// File: rtl/pqp_pkg.sv
// Shared definitions for the PicoQuickProcessor memory arbiter: FSM states,
// requester owner encoding and default bus widths.
package pqp_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Down-counter preload so that WAIT spans exactly lat cycles.
    function automatic logic [2:0] wait_load(input int lat);
        return 3'(lat - 1);
    endfunction

endpackage

// File: rtl/pqp_rr_arb2.sv
// Two-input round-robin picker. The winner is combinational; the last-granted
// owner is updated when the upd strobe marks an issued transaction.
module pqp_rr_arb2
    import pqp_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic req_d,
    input  logic upd,
    input  logic upd_owner,
    output logic winner
);

    logic last_r;

    // Last-granted owner; starts at D so I wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_r <= OWNER_D;
        end else if (upd) begin
            last_r <= upd_owner;
        end else begin
            last_r <= last_r;
        end
    end

    // Pick the sole requester, or the port not granted last on a tie.
    always_comb begin
        winner = OWNER_I;
        if (req_i && req_d) begin
            winner = ~last_r;
        end else if (req_d) begin
            winner = OWNER_D;
        end else begin
            winner = OWNER_I;
        end
    end

endmodule

// File: rtl/pqp_mem_arbiter.sv
// Shares one fixed-latency synchronous memory between the fetch (I) and
// load/store (D) ports, one transaction at a time, with fetch cancellation.
module pqp_mem_arbiter
    import pqp_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [2:0] LAT_LOAD = wait_load(MEM_LAT);

    state_t              state_r;
    state_t              state_next_s;
    logic [2:0]          cnt_r;
    logic                owner_r;
    logic                txn_we_r;
    logic                cancel_r;
    logic                winner_s;
    logic                start_s;
    logic                done_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;

    logic                i_gnt_r;
    logic                i_rvalid_r;
    logic [DATA_W-1:0]   i_rdata_r;
    logic                d_gnt_r;
    logic                d_rvalid_r;
    logic [DATA_W-1:0]   d_rdata_r;
    logic                mem_en_r;
    logic                mem_we_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;

    pqp_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (i_req),
        .req_d     (d_req),
        .upd       (state_r == ISSUE),
        .upd_owner (owner_r),
        .winner    (winner_s)
    );

    // Arbitration window, completion detect and winner's request fields.
    always_comb begin
        start_s     = 1'b0;
        done_s      = 1'b0;
        sel_we_s    = 1'b0;
        sel_addr_s  = i_addr;
        sel_wdata_s = '0;
        if ((state_r == IDLE) || (state_r == RESP)) begin
            start_s = i_req || d_req;
        end else begin
            start_s = 1'b0;
        end
        if ((state_r == WAIT) && (cnt_r == 3'd0)) begin
            done_s = 1'b1;
        end else begin
            done_s = 1'b0;
        end
        if (winner_s == OWNER_D) begin
            sel_we_s    = d_we;
            sel_addr_s  = d_addr;
            sel_wdata_s = d_wdata;
        end else begin
            sel_we_s    = 1'b0;
            sel_addr_s  = i_addr;
            sel_wdata_s = '0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, RESP: begin
                if (start_s) state_next_s = ISSUE;
                else         state_next_s = IDLE;
            end
            ISSUE: state_next_s = WAIT;
            WAIT: begin
                if (cnt_r == 3'd0) state_next_s = RESP;
                else               state_next_s = WAIT;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state, latency counter and per-transaction bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= IDLE;
            cnt_r    <= 3'd0;
            owner_r  <= OWNER_I;
            txn_we_r <= 1'b0;
            cancel_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (state_r == ISSUE)                   cnt_r <= LAT_LOAD;
            else if ((state_r == WAIT) && !done_s)  cnt_r <= cnt_r - 3'd1;
            else                                    cnt_r <= cnt_r;
            if (start_s) begin
                owner_r  <= winner_s;
                txn_we_r <= sel_we_s;
            end else begin
                owner_r  <= owner_r;
                txn_we_r <= txn_we_r;
            end
            if (start_s)
                cancel_r <= 1'b0;
            else if ((state_r != IDLE) && (owner_r == OWNER_I) && i_flush)
                cancel_r <= 1'b1;
            else
                cancel_r <= cancel_r;
        end
    end

    // Registered handshake, memory strobe and response data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            i_gnt_r     <= 1'b0;
            d_gnt_r     <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            i_rvalid_r  <= 1'b0;
            d_rvalid_r  <= 1'b0;
            i_rdata_r   <= '0;
            d_rdata_r   <= '0;
        end else begin
            i_gnt_r     <= start_s && (winner_s == OWNER_I);
            d_gnt_r     <= start_s && (winner_s == OWNER_D);
            mem_en_r    <= start_s;
            mem_we_r    <= start_s && sel_we_s;
            mem_addr_r  <= start_s ? sel_addr_s : '0;
            mem_wdata_r <= (start_s && sel_we_s) ? sel_wdata_s : '0;
            i_rvalid_r  <= done_s && (owner_r == OWNER_I) && !cancel_r && !i_flush;
            d_rvalid_r  <= done_s && (owner_r == OWNER_D);
            if (done_s && (owner_r == OWNER_I)) i_rdata_r <= mem_rdata;
            else                                i_rdata_r <= i_rdata_r;
            if (done_s && (owner_r == OWNER_D)) d_rdata_r <= txn_we_r ? '0 : mem_rdata;
            else                                d_rdata_r <= d_rdata_r;
        end
    end

    assign i_gnt     = i_gnt_r;
    // A flush arriving in the RESP cycle itself must still hide the response.
    assign i_rvalid  = i_rvalid_r & ~i_flush;
    assign i_rdata   = i_rdata_r;
    assign d_gnt     = d_gnt_r;
    assign d_rvalid  = d_rvalid_r;
    assign d_rdata   = d_rdata_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_pqp_mem_arbiter.sv
// Directed self-checking bench for pqp_mem_arbiter at MEM_LAT=1 with a
// behavioural one-cycle-latency memory.
module tb_pqp_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0, i_flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [0:63];
    logic [31:0] rdata_q = 32'h0;
    int          errors = 0;
    int          checks = 0;

    pqp_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
            rdata_q <= mem[mem_addr[7:2]];
        end
    end
    assign mem_rdata = rdata_q;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if ({i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy} !== 7'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL %s: ctl=%b addr=%h wdata=%h irdata=%h drdata=%h, required all 0", name,
                     {i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy}, mem_addr, mem_wdata, i_rdata, d_rdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(); step();
        check_quiet("reset_hold");
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_quiet("reset_idle");
        end
    endtask

    task automatic test_i_read();
        i_req = 1'b1; i_addr = 32'h10;
        step();
        checks++;
        if ({i_gnt, d_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 32'h10) begin
            errors++;
            $display("FAIL i_read_issue: gnt/dgnt/en/we=%b addr=%h, required 1010 addr 00000010",
                     {i_gnt, d_gnt, mem_en, mem_we}, mem_addr);
        end
        i_req = 1'b0;
        step();
        checks++;
        if (i_rvalid !== 1'b0 || busy !== 1'b1 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL i_read_wait: rvalid=%b busy=%b en=%b, required 0 1 0", i_rvalid, busy, mem_en);
        end
        step();
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'hDEADBEEF || d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL i_read_resp: rvalid=%b rdata=%h drvalid=%b, required 1 deadbeef 0", i_rvalid, i_rdata, d_rvalid);
        end
        step();
        checks++;
        if (i_rvalid !== 1'b0 || busy !== 1'b0 || i_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL i_read_after: rvalid=%b busy=%b rdata=%h, required 0 0 deadbeef", i_rvalid, busy, i_rdata);
        end
    endtask

    task automatic test_d_write();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h42;
        step();
        checks++;
        if ({d_gnt, i_gnt, mem_en, mem_we} !== 4'b1011 || mem_addr !== 32'h20 || mem_wdata !== 32'h42) begin
            errors++;
            $display("FAIL d_write_issue: dgnt/ignt/en/we=%b addr=%h wdata=%h, required 1011 00000020 00000042",
                     {d_gnt, i_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
        end
        d_req = 1'b0; d_we = 1'b0;
        step();
        step();
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || i_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL d_write_resp: rvalid=%b rdata=%h irvalid=%b, required 1 00000000 0", d_rvalid, d_rdata, i_rvalid);
        end
        step();
    endtask

    task automatic test_rr_tie();
        logic exp_i, exp_d;
        i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        for (int k = 1; k <= 9; k++) begin
            step();
            exp_i = (k % 3 == 1) && ((k / 3) % 2 == 0);
            exp_d = (k % 3 == 1) && ((k / 3) % 2 == 1);
            checks++;
            if (i_gnt !== exp_i || d_gnt !== exp_d) begin
                errors++;
                $display("FAIL rr_gnt_c%0d: ignt=%b dgnt=%b, required %b %b", k, i_gnt, d_gnt, exp_i, exp_d);
            end
            if (k == 3 || k == 6 || k == 9) begin
                checks++;
                if (i_rvalid !== (k != 6) || d_rvalid !== (k == 6) ||
                    (k == 6 && d_rdata !== 32'h42) || (k != 6 && i_rdata !== 32'hDEADBEEF)) begin
                    errors++;
                    $display("FAIL rr_resp_c%0d: irv=%b drv=%b irdata=%h drdata=%h", k, i_rvalid, d_rvalid, i_rdata, d_rdata);
                end
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        step();
    endtask

    task automatic test_flush();
        i_req = 1'b1; i_addr = 32'h10;
        step();
        checks++;
        if (i_gnt !== 1'b1) begin
            errors++;
            $display("FAIL flush_gnt: ignt=%b, required 1", i_gnt);
        end
        i_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        step();
        i_flush = 1'b1;
        checks++;
        if (d_gnt !== 1'b0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL flush_wait_ignore: dgnt=%b en=%b, required 0 0", d_gnt, mem_en);
        end
        step();
        i_flush = 1'b0;
        checks++;
        if (i_rvalid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_suppress: irvalid=%b busy=%b, required 0 1", i_rvalid, busy);
        end
        step();
        checks++;
        if (d_gnt !== 1'b1 || i_rvalid !== 1'b0 || mem_addr !== 32'h20) begin
            errors++;
            $display("FAIL flush_d_follow: dgnt=%b irvalid=%b addr=%h, required 1 0 00000020", d_gnt, i_rvalid, mem_addr);
        end
        d_req = 1'b0;
        step();
        step();
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h42 || i_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL flush_d_resp: drvalid=%b drdata=%h irvalid=%b, required 1 00000042 0", d_rvalid, d_rdata, i_rvalid);
        end
        step();
        // Flush raised during the RESP cycle itself.
        i_req = 1'b1; i_addr = 32'h10;
        step();
        i_req = 1'b0;
        step();
        step();
        checks++;
        if (i_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL flush_resp_pre: irvalid=%b, required 1", i_rvalid);
        end
        i_flush = 1'b1;
        #1;
        checks++;
        if (i_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_resp: irvalid=%b, required 0", i_rvalid);
        end
        step();
        i_flush = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        i_req = 1'b1; i_addr = 32'h10;
        step();
        i_req = 1'b0;
        step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_wait: busy=%b, required 1", busy);
        end
        rst = 1'b0;
        step();
        check_quiet("rst_mid_clear");
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_quiet("rst_mid_no_rvalid");
        end
    endtask

    initial begin
        for (int a = 0; a < 64; a++) mem[a] = 32'h0;
        mem[4] = 32'hDEADBEEF;
        test_reset();
        test_i_read();
        test_d_write();
        test_rr_tie();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
